// File: rtl/uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// uart_alu_ctrl
//
// Packet controller between the UART receive/transmit byte streams and the
// ALU datapath. A packet is a 4-byte header (opcode, reserved, length LSB,
// length MSB) followed by a payload. The length counts the header bytes.
// The payload is echoed, folded into a 32-bit accumulator (the 4-byte result
// is then returned LSB-first) or drained when the header is bad.
//
// Optional feature: define UART_ALU_MUL_EN to decode MUL_OPCODE and build
// the 32x32 multiplier. Without it, MUL_OPCODE is an unknown opcode.
//
// Ports:
//   clk_i        in   single clock
//   reset_i      in   synchronous active-high reset
//   rx_tdata_i   in   [7:0] receive byte
//   rx_tvalid_i  in   receive byte valid
//   rx_tready_o  out  receive byte accepted
//   tx_tdata_o   out  [7:0] transmit byte
//   tx_tvalid_o  out  transmit byte valid
//   tx_tready_i  in   transmitter accepts the byte
//   busy_o       out  high whenever a packet is in progress
//   error_o      out  one-cycle pulse on a bad header
// ---------------------------------------------------------------------------
module uart_alu_ctrl #(
    parameter logic [7:0] ECHO_OPCODE = 8'hEC,
    parameter logic [7:0] ADD_OPCODE  = 8'h01,
    parameter logic [7:0] MUL_OPCODE  = 8'h10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_tdata_i,
    input  logic       rx_tvalid_i,
    output logic       rx_tready_o,
    output logic [7:0] tx_tdata_o,
    output logic       tx_tvalid_o,
    input  logic       tx_tready_i,
    output logic       busy_o,
    output logic       error_o
);

    typedef enum logic [2:0] {
        S_OPCODE  = 3'd0,
        S_RSVD    = 3'd1,
        S_LEN_LO  = 3'd2,
        S_LEN_HI  = 3'd3,
        S_ECHO    = 3'd4,
        S_OPERAND = 3'd5,
        S_DRAIN   = 3'd6,
        S_RESULT  = 3'd7
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  opcode_r;
    logic [7:0]  len_lo_r;
    logic [15:0] rem_r;
    logic [1:0]  idx_r;
    logic        first_r;
    logic [31:0] acc_r;
    logic [23:0] opnd_r;
    logic        error_r;
    logic [7:0]  tx_byte_r;

    logic        rx_ready_s;
    logic        tx_valid_s;
    logic [7:0]  tx_data_s;
    logic        rx_xfer_s;
    logic        err_set_s;
    logic [15:0] len_s;
    logic [15:0] rem_load_s;
    logic        is_mul_s;
    logic        is_arith_s;
    logic        len_ok_s;
    logic [31:0] word_s;
    logic [31:0] acc_next_s;

    // Select one byte of a 32-bit word, byte 0 being the LSB.
    function automatic logic [7:0] word_byte(input logic [31:0] v, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = v[7:0];
            2'd1:    b = v[15:8];
            2'd2:    b = v[23:16];
            2'd3:    b = v[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign rx_xfer_s  = rx_tvalid_i && rx_ready_s;
    assign len_s      = {rx_tdata_i, len_lo_r};
    assign rem_load_s = len_s - 16'd4;
    assign len_ok_s   = (len_s >= 16'd8) && (len_s[1:0] == 2'b00);
    assign is_mul_s   = (opcode_r == MUL_OPCODE);
    // The incoming byte completes the word when idx_r == 3.
    assign word_s     = {rx_tdata_i, opnd_r};

`ifdef UART_ALU_MUL_EN
    logic [31:0] prod_s;
    assign is_arith_s = (opcode_r == ADD_OPCODE) || is_mul_s;
    assign prod_s     = acc_r * word_s;
    assign acc_next_s = first_r  ? word_s :
                        is_mul_s ? prod_s : (acc_r + word_s);
`else
    // Without the multiplier, the MUL code is never arithmetic.
    assign is_arith_s = (opcode_r == ADD_OPCODE) && !is_mul_s;
    assign acc_next_s = first_r ? word_s : (acc_r + word_s);
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= S_OPCODE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic, including header dispatch and error detection.
    always_comb begin
        state_next_s = state_r;
        err_set_s    = 1'b0;
        case (state_r)
            S_OPCODE: begin
                if (rx_xfer_s) state_next_s = S_RSVD;
                else           state_next_s = S_OPCODE;
            end
            S_RSVD: begin
                if (rx_xfer_s) state_next_s = S_LEN_LO;
                else           state_next_s = S_RSVD;
            end
            S_LEN_LO: begin
                if (rx_xfer_s) state_next_s = S_LEN_HI;
                else           state_next_s = S_LEN_LO;
            end
            S_LEN_HI: begin
                if (!rx_xfer_s) begin
                    state_next_s = S_LEN_HI;
                end else if (len_s < 16'd4) begin
                    err_set_s    = 1'b1;
                    state_next_s = S_OPCODE;
                end else if (opcode_r == ECHO_OPCODE) begin
                    if (len_s == 16'd4) state_next_s = S_OPCODE;
                    else                state_next_s = S_ECHO;
                end else if (is_arith_s && len_ok_s) begin
                    state_next_s = S_OPERAND;
                end else begin
                    err_set_s = 1'b1;
                    if (rem_load_s == 16'd0) state_next_s = S_OPCODE;
                    else                     state_next_s = S_DRAIN;
                end
            end
            S_ECHO, S_DRAIN: begin
                if (rx_xfer_s && (rem_r == 16'd1)) state_next_s = S_OPCODE;
                else                                state_next_s = state_r;
            end
            S_OPERAND: begin
                if (rx_xfer_s && (rem_r == 16'd1)) state_next_s = S_RESULT;
                else                                state_next_s = S_OPERAND;
            end
            S_RESULT: begin
                if (tx_tready_i && (idx_r == 2'd3)) state_next_s = S_OPCODE;
                else                                 state_next_s = S_RESULT;
            end
            default: state_next_s = S_OPCODE;
        endcase
    end

    // Output decode; reset forces every output low.
    always_comb begin
        rx_ready_s = 1'b0;
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
        if (reset_i) begin
            rx_ready_s = 1'b0;
        end else begin
            case (state_r)
                S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN: begin
                    rx_ready_s = 1'b1;
                end
                S_ECHO: begin
                    rx_ready_s = tx_tready_i;
                    tx_valid_s = rx_tvalid_i;
                    tx_data_s  = rx_tdata_i;
                end
                S_RESULT: begin
                    tx_valid_s = 1'b1;
                    tx_data_s  = tx_byte_r;
                end
                default: begin
                    rx_ready_s = 1'b0;
                end
            endcase
        end
    end

    assign rx_tready_o = rx_ready_s;
    assign tx_tvalid_o = tx_valid_s;
    assign tx_tdata_o  = tx_data_s;
    assign busy_o      = !reset_i && (state_r != S_OPCODE);
    assign error_o     = !reset_i && error_r;

    // Header capture, remaining-byte counter, operand assembly, accumulator
    // and result byte register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            opcode_r  <= 8'h00;
            len_lo_r  <= 8'h00;
            rem_r     <= 16'd0;
            idx_r     <= 2'd0;
            first_r   <= 1'b0;
            acc_r     <= 32'd0;
            opnd_r    <= 24'd0;
            error_r   <= 1'b0;
            tx_byte_r <= 8'h00;
        end else begin
            error_r <= err_set_s;
            case (state_r)
                S_OPCODE: begin
                    if (rx_xfer_s) opcode_r <= rx_tdata_i;
                end
                S_LEN_LO: begin
                    if (rx_xfer_s) len_lo_r <= rx_tdata_i;
                end
                S_LEN_HI: begin
                    if (rx_xfer_s) begin
                        rem_r   <= rem_load_s;
                        idx_r   <= 2'd0;
                        first_r <= 1'b1;
                    end
                end
                S_ECHO, S_DRAIN: begin
                    if (rx_xfer_s) rem_r <= rem_r - 16'd1;
                end
                S_OPERAND: begin
                    if (rx_xfer_s) begin
                        rem_r <= rem_r - 16'd1;
                        idx_r <= idx_r + 2'd1;
                        case (idx_r)
                            2'd0: opnd_r[7:0]   <= rx_tdata_i;
                            2'd1: opnd_r[15:8]  <= rx_tdata_i;
                            2'd2: opnd_r[23:16] <= rx_tdata_i;
                            2'd3: begin
                                acc_r   <= acc_next_s;
                                first_r <= 1'b0;
                            end
                            default: opnd_r <= opnd_r;
                        endcase
                        // Last operand byte: preload result byte 0 so it is
                        // on tx the very next cycle.
                        if (rem_r == 16'd1) tx_byte_r <= acc_next_s[7:0];
                    end
                end
                S_RESULT: begin
                    if (tx_tready_i) begin
                        idx_r     <= idx_r + 2'd1;
                        tx_byte_r <= word_byte(acc_r, idx_r + 2'd1);
                    end
                end
                default: begin
                    rem_r <= rem_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h10;
`ifdef UART_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic       rx_tready;
    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tready;
    logic       busy;
    logic       error;

    int n_vec = 0;
    int n_bad = 0;
    int stall_left = 0;

    always #5 clk = ~clk;

    uart_alu_ctrl dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .rx_tdata_i  (rx_tdata),
        .rx_tvalid_i (rx_tvalid),
        .rx_tready_o (rx_tready),
        .tx_tdata_o  (tx_tdata),
        .tx_tvalid_o (tx_tvalid),
        .tx_tready_i (tx_tready),
        .busy_o      (busy),
        .error_o     (error)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Send one packet with random valid gaps and random tx backpressure,
    // collect everything the DUT transmits, and compare with the reference.
    task automatic run_pkt(input logic [7:0] op, input int len, input logic [7:0] pl[$]);
        logic [7:0]  pkt[$];
        logic [7:0]  exp_q[$];
        logic [7:0]  got[$];
        logic [15:0] l16;
        logic [31:0] acc;
        logic [31:0] w;
        int  exp_err;
        int  errs;
        int  i;
        int  cyc;
        int  last_rx;
        int  first_tx;
        bit  hold;
        bit  pend;
        bit  arith_ok;
        logic [7:0] pend_data;

        // reference model
        exp_err  = 0;
        arith_ok = 1'b0;
        acc      = 32'd0;
        if (len < 4) begin
            exp_err = 1;
        end else if (op == OP_ECHO) begin
            exp_q = pl;
        end else if ((op == OP_ADD || (MUL_EN && op == OP_MUL)) && len >= 8 && (len % 4) == 0) begin
            arith_ok = 1'b1;
            for (int j = 0; j < pl.size() / 4; j++) begin
                w = {pl[4*j+3], pl[4*j+2], pl[4*j+1], pl[4*j]};
                if (j == 0)           acc = w;
                else if (op == OP_ADD) acc = acc + w;
                else                   acc = acc * w;
            end
            exp_q = '{acc[7:0], acc[15:8], acc[23:16], acc[31:24]};
        end else begin
            exp_err = 1;
        end

        l16 = len[15:0];
        pkt = '{op, 8'($urandom_range(0, 255)), l16[7:0], l16[15:8]};
        foreach (pl[k]) pkt.push_back(pl[k]);

        i = 0; cyc = 0; errs = 0; last_rx = -1; first_tx = -1;
        hold = 1'b0; pend = 1'b0; pend_data = 8'h00;
        while (cyc < 3000) begin
            @(negedge clk);
            if (!hold) begin
                rx_tvalid = (i < pkt.size()) && ($urandom_range(0, 3) != 0);
                rx_tdata  = (i < pkt.size()) ? pkt[i] : 8'h00;
            end
            if (stall_left > 0) tx_tready = 1'b0;
            else                tx_tready = ($urandom_range(0, 3) != 0);
            #2;
            if (pend) begin
                check_val("tx_hold_valid", 32'(tx_tvalid), 32'd1);
                check_val("tx_hold_data", 32'(tx_tdata), 32'(pend_data));
            end
            pend      = tx_tvalid && !tx_tready;
            pend_data = tx_tdata;
            if (tx_tvalid && stall_left > 0) stall_left--;
            if (tx_tvalid && first_tx < 0) first_tx = cyc;
            if (tx_tvalid && tx_tready) got.push_back(tx_tdata);
            if (error) errs++;
            hold = rx_tvalid && !rx_tready;
            if (rx_tvalid && rx_tready) begin
                i++;
                if (i == pkt.size()) last_rx = cyc;
            end
            cyc++;
            if (i == pkt.size() && !busy && !tx_tvalid) break;
        end
        rx_tvalid = 1'b0;
        tx_tready = 1'b1;
        if (cyc >= 3000) check_val("timeout", 32'd1, 32'd0);

        check_val("error_pulses", 32'(errs), 32'(exp_err));
        check_val("tx_count", 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            check_val("tx_byte", (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(exp_q[k]));
        end
        if (arith_ok) check_val("result_latency", 32'(first_tx - last_rx), 32'd1);
    endtask

    task automatic reset_outputs_check(input string tag);
        check_val({tag, "_rx_tready"}, 32'(rx_tready), 32'd0);
        check_val({tag, "_tx_tvalid"}, 32'(tx_tvalid), 32'd0);
        check_val({tag, "_tx_tdata"},  32'(tx_tdata),  32'd0);
        check_val({tag, "_busy"},      32'(busy),      32'd0);
        check_val({tag, "_error"},     32'(error),     32'd0);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] partial[$];
        logic [7:0] op;
        int len;
        int r;

        reset     = 1'b1;
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h00;
        tx_tready = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_outputs_check("por");
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_val("post_reset_rx_tready", 32'(rx_tready), 32'd1);
        check_val("post_reset_busy", 32'(busy), 32'd0);

        // directed cases
        pl = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        run_pkt(OP_ADD, 12, pl);
        pl = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        run_pkt(OP_ADD, 12, pl);
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_pkt(OP_ECHO, 8, pl);
        pl = {};
        run_pkt(OP_ECHO, 4, pl);
        pl = '{8'h11, 8'h22, 8'h33};
        run_pkt(OP_ADD, 7, pl);
        pl = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
        run_pkt(OP_ADD, 12, pl);
        pl = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        run_pkt(OP_MUL, 12, pl);
        pl = {};
        run_pkt(OP_ADD, 2, pl);

        // backpressure: tx_tready low for the first 10 result cycles
        stall_left = 10;
        pl = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00};
        run_pkt(OP_ADD, 12, pl);
        check_val("stall_consumed", 32'(stall_left), 32'd0);

        // reset in the middle of an operand
        partial = '{OP_ADD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00};
        foreach (partial[k]) begin
            @(negedge clk);
            rx_tvalid = 1'b1;
            rx_tdata  = partial[k];
        end
        @(negedge clk);
        rx_tvalid = 1'b0;
        reset     = 1'b1;
        #2 reset_outputs_check("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_val("mid_reset_after_rx_tready", 32'(rx_tready), 32'd1);
        check_val("mid_reset_after_busy", 32'(busy), 32'd0);
        check_val("mid_reset_after_tx_tvalid", 32'(tx_tvalid), 32'd0);
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
        run_pkt(OP_ADD, 12, pl);

        // randomized packets
        for (int p = 0; p < 40; p++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      op = OP_ADD;
            else if (r < 6) op = OP_MUL;
            else if (r < 8) op = OP_ECHO;
            else            op = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            if (r == 0)      len = $urandom_range(0, 3);
            else if (r == 1) len = 4;
            else if (r == 2) len = 4 + $urandom_range(1, 15);
            else             len = 4 * $urandom_range(2, 6);
            pl = {};
            for (int k = 0; k < ((len >= 4) ? len - 4 : 0); k++) pl.push_back(8'($urandom_range(0, 255)));
            run_pkt(op, len, pl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Packet controller between the UART receive/transmit byte streams and the ALU datapath inside `uart_alu`. It parses the 4-byte packet header (opcode, reserved, length LSB, length MSB), then does one of three things with the payload: forwards it back out (echo), folds it into a 32-bit accumulator (arithmetic), or drains it (error). After an arithmetic packet it returns the 4-byte result LSB-first. Both sides use AXI-stream style byte handshakes.

## Interface
- `ECHO_OPCODE`, default 8'hEC: opcode for echo.
- `ADD_OPCODE`, default 8'h01: opcode for the 32-bit sum of all operands.
- `MUL_OPCODE`, default 8'h10: opcode for the 32-bit product of all operands; only decoded with `UART_ALU_MUL_EN`.
- `clk_i` in 1: the single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `rx_tdata_i` in 8: byte from the UART receiver.
- `rx_tvalid_i` in 1: receive byte valid.
- `rx_tready_o` out 1: controller accepts the receive byte.
- `tx_tdata_o` out 8: byte to the UART transmitter.
- `tx_tvalid_o` out 1: transmit byte valid.
- `tx_tready_i` in 1: transmitter accepts the byte.
- `busy_o` out 1: high in every state except OPCODE.
- `error_o` out 1: one-cycle pulse on a bad header.

## Operation
- States:
  - OPCODE, RSVD, LEN_LO, LEN_HI: header, one byte each.
  - ECHO, OPERAND, DRAIN: payload handling.
  - RESULT: returning the 4-byte result.
- Transfer rule: a byte moves only when valid && ready on the same edge.
- Header:
  - RSVD byte is ignored.
  - `len` = {LEN_HI byte, LEN_LO byte} and includes the 4 header bytes.
  - `rem` (16-bit remaining-byte counter) = len-4, loaded on the LEN_HI transfer.
- Dispatch on the LEN_HI transfer:
  - `len<4`: error_o pulse, go to OPCODE.
  - ECHO_OPCODE, `len==4`: go to OPCODE with no output.
  - ECHO_OPCODE otherwise: go to ECHO.
  - Arithmetic opcode with `len>=8` and `len[1:0]==0`: go to OPERAND.
  - Arithmetic opcode otherwise, or unknown opcode: error_o pulse, go to DRAIN (go to OPCODE instead if rem==0).
- ECHO is combinational passthrough:
  - tx_tvalid_o=rx_tvalid_i, tx_tdata_o=rx_tdata_i, rx_tready_o=tx_tready_i.
  - rem decrements per transfer; go to OPCODE on the transfer that brings rem to 0.
- OPERAND:
  - Operands are assembled little-endian: the byte index k within a word (k=0..3) writes bits [8k+7:8k].
  - First operand of a packet loads the accumulator.
  - Each later operand combines with it: ADD adds, MUL keeps the low 32 bits of the product; both wrap mod 2^32.
  - Go to RESULT when rem reaches 0.
- RESULT: drives accumulator bytes 0,1,2,3 in order from a registered output; returns to OPCODE after byte 3 is accepted.
- DRAIN: rx_tready_o=1; bytes are discarded until rem reaches 0; nothing is transmitted.
- rx_tready_o by state: 1 in OPCODE, RSVD, LEN_LO, LEN_HI, OPERAND and DRAIN; 0 in RESULT.

## Timing
- While reset_i is high:
  - rx_tready_o=0, tx_tvalid_o=0, tx_tdata_o=0, busy_o=0, error_o=0.
  - Next state is OPCODE; accumulator, rem and byte index are cleared.
- First cycle after reset is released: rx_tready_o=1.
- Throughput: one byte per cycle on the receive side in the header, OPERAND and DRAIN states.
- Result latency: last operand byte accepted at edge N; accumulator updates at edge N; tx_tvalid_o=1 with byte 0 from cycle N+1.
- Backpressure: tx_tdata_o holds stable while tx_tvalid_o && !tx_tready_i; the next byte is presented the cycle after the handshake.
- error_o: asserted the cycle after the LEN_HI transfer, for exactly one cycle.
- Reset mid-packet: partial state is discarded at the reset edge; no residual tx_tvalid_o afterwards.
- Header bytes are never forwarded to tx.

## Configuration
- `UART_ALU_MUL_EN` defined: MUL_OPCODE is decoded as an arithmetic opcode and the multiplier is instantiated.
- `UART_ALU_MUL_EN` undefined: MUL_OPCODE is treated as an unknown opcode (error_o pulse, payload drained) and no multiplier logic is present.

## Test plan
- ADD, len=12, operands 0x00000005 and 0x00000007 -> tx bytes 0C 00 00 00; busy_o low after the last handshake.
- ADD, len=12, operands 0xFFFFFFFF and 0x00000002 -> tx bytes 01 00 00 00 (wrap).
- ECHO, len=8, payload AA BB CC DD -> tx AA BB CC DD in order, no extra bytes; ECHO with len=4 -> no tx activity.
- ADD, len=7 -> error_o pulse, 3 payload bytes drained, no tx; a following valid ADD packet returns the correct sum.
- tx_tready_i held low for 10 cycles during RESULT -> byte 0 stays stable; reset_i asserted during OPERAND -> OPCODE next cycle with all outputs at reset values.
- MUL, operands 3 and 7 -> 15 00 00 00 with `UART_ALU_MUL_EN` defined; error_o pulse and drain with it undefined.
